// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: result select, $zero write suppression, stall/flush control.
// Optional retired-instruction counter built only when WB_RETIRE_CNT_EN is defined.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_mem,
  input  logic              RegWrite_mem,
  input  logic              MemtoReg_mem,
  input  logic              Jal_mem,
  input  logic [REG_AW-1:0] WriteReg_mem,
  input  logic [DATA_W-1:0] alu_res_mem,
  input  logic [DATA_W-1:0] Dout_mem,
  input  logic [DATA_W-1:0] pc_plus4_mem,
  input  logic              stall_wb,
  input  logic              flush_wb,
  output logic              RegWrite_wb,
  output logic [REG_AW-1:0] WriteReg_wb,
  output logic [DATA_W-1:0] reg_data_wb,
  output logic              valid_wb,
  output logic [31:0]       retire_cnt
);

  localparam logic [REG_AW-1:0] LinkReg = REG_AW'(31);

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_AW-1:0] dest_sel;
  logic [DATA_W-1:0] result_sel;
  logic              load_en;

  assign load_en = !flush_wb && !stall_wb;

  // Jal wins over MemtoReg in the result mux.
  always_comb begin
    dest_sel   = Jal_mem ? LinkReg : WriteReg_mem;
    result_sel = alu_res_mem;
    if (Jal_mem) begin
      result_sel = pc_plus4_mem;
    end else if (MemtoReg_mem) begin
      result_sel = Dout_mem;
    end
  end

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (flush_wb) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      dest_d  = '0;
      data_d  = '0;
    end else if (load_en) begin
      valid_d = valid_mem;
      we_d    = valid_mem && RegWrite_mem && (dest_sel != '0);
      dest_d  = dest_sel;
      data_d  = result_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign valid_wb    = valid_q;
  assign RegWrite_wb = we_q;
  assign WriteReg_wb = dest_q;
  assign reg_data_wb = data_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (load_en && valid_mem) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized traffic
// checked against a rule-level model. Retire-counter cases need WB_RETIRE_CNT_EN.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, valid_mem, RegWrite_mem, MemtoReg_mem, Jal_mem;
  logic [4:0]  WriteReg_mem;
  logic [31:0] alu_res_mem, Dout_mem, pc_plus4_mem;
  logic        stall_wb, flush_wb;
  logic        RegWrite_wb, valid_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] reg_data_wb, retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural state of the WB stage.
  logic        m_valid, m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_data, m_cnt;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_mem    (valid_mem),
    .RegWrite_mem (RegWrite_mem),
    .MemtoReg_mem (MemtoReg_mem),
    .Jal_mem      (Jal_mem),
    .WriteReg_mem (WriteReg_mem),
    .alu_res_mem  (alu_res_mem),
    .Dout_mem     (Dout_mem),
    .pc_plus4_mem (pc_plus4_mem),
    .stall_wb     (stall_wb),
    .flush_wb     (flush_wb),
    .RegWrite_wb  (RegWrite_wb),
    .WriteReg_wb  (WriteReg_wb),
    .reg_data_wb  (reg_data_wb),
    .valid_wb     (valid_wb),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic clear_inputs();
    rst = 0; valid_mem = 0; RegWrite_mem = 0; MemtoReg_mem = 0; Jal_mem = 0;
    WriteReg_mem = 0; alu_res_mem = 0; Dout_mem = 0; pc_plus4_mem = 0;
    stall_wb = 0; flush_wb = 0;
  endtask

  task automatic random_inputs();
    valid_mem    = $urandom_range(0, 3) != 0;
    RegWrite_mem = $urandom_range(0, 3) != 0;
    MemtoReg_mem = $urandom_range(0, 1) == 1;
    Jal_mem      = $urandom_range(0, 4) == 0;
    WriteReg_mem = 5'($urandom_range(0, 31));
    alu_res_mem  = $urandom;
    Dout_mem     = $urandom;
    pc_plus4_mem = $urandom;
  endtask

  // One clock edge; the model applies the rules to the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_we = 0; m_dest = 0; m_data = 0; m_cnt = 0;
    end else if (flush_wb) begin
      m_valid = 0; m_we = 0; m_dest = 0; m_data = 0;
    end else if (!stall_wb) begin
      m_valid = valid_mem;
      m_dest  = Jal_mem ? 5'd31 : WriteReg_mem;
      m_data  = Jal_mem ? pc_plus4_mem : (MemtoReg_mem ? Dout_mem : alu_res_mem);
      m_we    = valid_mem && RegWrite_mem && (m_dest != 0);
      if (valid_mem) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    random_inputs();
    stall_wb = 1; flush_wb = 0; rst = 1;
    tick();
    n_checks++;
    if ({valid_wb, RegWrite_wb, WriteReg_wb, reg_data_wb, retire_cnt} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset: got v=%0b we=%0b dest=%0d data=%h cnt=%h, want all zero",
               valid_wb, RegWrite_wb, WriteReg_wb, reg_data_wb, retire_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_alu();
    clear_inputs();
    valid_mem = 1; RegWrite_mem = 1; WriteReg_mem = 8; alu_res_mem = 32'h0000_1234;
    Dout_mem = 32'hFFFF_0000; pc_plus4_mem = 32'h44;
    tick();
    n_checks++;
    if (RegWrite_wb !== 1'b1 || WriteReg_wb !== 5'd8 || reg_data_wb !== 32'h1234) begin
      n_fail++;
      $display("FAIL alu_op: got we=%0b dest=%0d data=%h, want we=1 dest=8 data=00001234",
               RegWrite_wb, WriteReg_wb, reg_data_wb);
    end
  endtask

  task automatic test_load();
    clear_inputs();
    valid_mem = 1; RegWrite_mem = 1; MemtoReg_mem = 1; WriteReg_mem = 9;
    Dout_mem = 32'hDEAD_BEEF; alu_res_mem = 32'h40;
    tick();
    n_checks++;
    if (reg_data_wb !== 32'hDEAD_BEEF || WriteReg_wb !== 5'd9 || RegWrite_wb !== 1'b1) begin
      n_fail++;
      $display("FAIL load: got data=%h dest=%0d we=%0b, want data=deadbeef dest=9 we=1",
               reg_data_wb, WriteReg_wb, RegWrite_wb);
    end
  endtask

  task automatic test_jal();
    clear_inputs();
    valid_mem = 1; RegWrite_mem = 1; MemtoReg_mem = 1; Jal_mem = 1; WriteReg_mem = 0;
    pc_plus4_mem = 32'h10; Dout_mem = 32'h5555_5555; alu_res_mem = 32'h7777;
    tick();
    n_checks++;
    if (WriteReg_wb !== 5'd31 || reg_data_wb !== 32'h10 || RegWrite_wb !== 1'b1) begin
      n_fail++;
      $display("FAIL jal: got dest=%0d data=%h we=%0b, want dest=31 data=00000010 we=1",
               WriteReg_wb, reg_data_wb, RegWrite_wb);
    end
  endtask

  task automatic test_zero_dest();
    clear_inputs();
    valid_mem = 1; RegWrite_mem = 1; WriteReg_mem = 0; alu_res_mem = 32'hABCD;
    tick();
    n_checks++;
    if (RegWrite_wb !== 1'b0 || valid_wb !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_dest: got we=%0b v=%0b, want we=0 v=1", RegWrite_wb, valid_wb);
    end
    // Invalid instruction must not write even with RegWrite set.
    valid_mem = 0; WriteReg_mem = 4;
    tick();
    n_checks++;
    if (RegWrite_wb !== 1'b0 || valid_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_write: got we=%0b v=%0b, want we=0 v=0", RegWrite_wb, valid_wb);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    valid_mem = 1; RegWrite_mem = 1; WriteReg_mem = 12; alu_res_mem = 32'h600D_F00D;
    tick();
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      stall_wb = 1;
      tick();
      n_checks++;
      if (valid_wb !== 1'b1 || RegWrite_wb !== 1'b1 || WriteReg_wb !== 5'd12 ||
          reg_data_wb !== 32'h600D_F00D) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%0b we=%0b dest=%0d data=%h, want 1 1 12 600df00d",
                 i, valid_wb, RegWrite_wb, WriteReg_wb, reg_data_wb);
      end
    end
    random_inputs();
    stall_wb = 1; flush_wb = 1;
    tick();
    n_checks++;
    if (valid_wb !== 1'b0 || RegWrite_wb !== 1'b0 || WriteReg_wb !== 5'd0 ||
        reg_data_wb !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_over_stall: got v=%0b we=%0b dest=%0d data=%h, want all zero",
               valid_wb, RegWrite_wb, WriteReg_wb, reg_data_wb);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      stall_wb = $urandom_range(0, 4) == 0;
      flush_wb = $urandom_range(0, 7) == 0;
      rst      = $urandom_range(0, 49) == 0;
      tick();
      n_checks++;
      if (valid_wb !== m_valid || RegWrite_wb !== m_we || WriteReg_wb !== m_dest ||
          reg_data_wb !== m_data || retire_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b we=%0b dest=%0d data=%h cnt=%h, want %0b %0b %0d %h %h",
                 i, valid_wb, RegWrite_wb, WriteReg_wb, reg_data_wb, retire_cnt,
                 m_valid, m_we, m_dest, m_data, exp_cnt());
      end
      n_checks++;
      if (RegWrite_wb && (!valid_wb || WriteReg_wb == 0)) begin
        n_fail++;
        $display("FAIL we_invariant[%0d]: got we=1 v=%0b dest=%0d, want we=0",
                 i, valid_wb, WriteReg_wb);
      end
    end
    clear_inputs();
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    // 5 valid loads interleaved with 2 stalls and 1 flush.
    for (int i = 0; i < 8; i++) begin
      random_inputs();
      valid_mem = 1;
      stall_wb  = (i == 2 || i == 5);
      flush_wb  = (i == 6);
      tick();
    end
    n_checks++;
    if (retire_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL retire_count: got %0d, want 5", retire_cnt);
    end
    clear_inputs();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    valid_mem = 1;
    tick();
    n_checks++;
    if (retire_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL retire_wrap: got %h, want 00000000", retire_cnt);
    end
    for (int i = 0; i < 3; i++) tick();
    rst = 1; stall_wb = 1;
    tick();
    n_checks++;
    if (retire_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL retire_reset: got %0d, want 0", retire_cnt);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    m_valid = 0; m_we = 0; m_dest = 0; m_data = 0; m_cnt = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_jal();
    test_zero_dest();
    test_stall_flush();
    test_random();
`ifdef WB_RETIRE_CNT_EN
    test_retire();
`endif
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
